// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte input and decoded command/error bundle for uart_cmd_parser
interface uart_cmd_parser_if #(
  parameter int ID_W  = 8,
  parameter int ARG_W = 16
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             cmd_valid;
  logic [ID_W-1:0]  cmd_id;
  logic [ARG_W-1:0] cmd_arg1;
  logic [ARG_W-1:0] cmd_arg2;
  logic [1:0]       cmd_argc;
  logic             cmd_err;
  logic [2:0]       err_code;

  modport master (
    output rx_valid, rx_data,
    input  cmd_valid, cmd_id, cmd_arg1, cmd_arg2, cmd_argc, cmd_err, err_code
  );

  modport slave (
    input  rx_valid, rx_data,
    output cmd_valid, cmd_id, cmd_arg1, cmd_arg2, cmd_argc, cmd_err, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - parses "$id[,a1[,a2]]\r\n" byte frames into command or error strobes
module uart_cmd_parser #(
  parameter int ID_W  = 8,
  parameter int ARG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_parser_if.slave  bus
);
  localparam int AW = (ID_W > ARG_W) ? ID_W : ARG_W;
  localparam int MW = AW + 4;

  localparam logic [2:0] E_BADCHAR  = 3'd1;
  localparam logic [2:0] E_OVERFLOW = 3'd2;
  localparam logic [2:0] E_TOOMANY  = 3'd3;
  localparam logic [2:0] E_EMPTY    = 3'd4;
  localparam logic [2:0] E_NOLF     = 3'd5;

  localparam logic [MW-1:0] ID_MAX  = {{(MW-ID_W){1'b0}}, {ID_W{1'b1}}};
  localparam logic [MW-1:0] ARG_MAX = {{(MW-ARG_W){1'b0}}, {ARG_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, FIELD, WAIT_LF, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             seen_q, seen_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ARG_W-1:0] a1_q, a1_d;
  logic [ARG_W-1:0] a2_q, a2_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
  logic [ARG_W-1:0] cmd_arg1_q, cmd_arg1_d;
  logic [ARG_W-1:0] cmd_arg2_q, cmd_arg2_d;
  logic [1:0]       cmd_argc_q, cmd_argc_d;
  logic             cmd_err_q, cmd_err_d;
  logic [2:0]       err_code_q, err_code_d;

  logic          is_digit, is_dollar, is_comma, is_space, is_cr, is_lf;
  logic [MW-1:0] acc_ext, acc_mul, field_max;
  logic          do_start, do_err, do_store;
  logic [2:0]    err_sel;

  assign is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign is_dollar = (bus.rx_data == 8'h24);
  assign is_comma  = (bus.rx_data == 8'h2C);
  assign is_space  = (bus.rx_data == 8'h20);
  assign is_cr     = (bus.rx_data == 8'h0D);
  assign is_lf     = (bus.rx_data == 8'h0A);

  // acc*10 + digit; the 4 spare bits keep the product exact before the range check.
  assign acc_ext   = {4'b0000, acc_q};
  assign acc_mul   = (acc_ext << 3) + (acc_ext << 1) + {{(MW-4){1'b0}}, bus.rx_data[3:0]};
  assign field_max = (idx_q == 2'd0) ? ID_MAX : ARG_MAX;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    seen_d      = seen_q;
    id_d        = id_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    cmd_valid_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    cmd_arg1_d  = cmd_arg1_q;
    cmd_arg2_d  = cmd_arg2_q;
    cmd_argc_d  = cmd_argc_q;
    cmd_err_d   = 1'b0;
    err_code_d  = err_code_q;
    do_start    = 1'b0;
    do_err      = 1'b0;
    do_store    = 1'b0;
    err_sel     = E_BADCHAR;

    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_dollar) do_start = 1'b1;
        end
        FIELD: begin
          if (is_digit) begin
            if (acc_mul > field_max) begin
              do_err  = 1'b1;
              err_sel = E_OVERFLOW;
            end else begin
              acc_d  = acc_mul[AW-1:0];
              seen_d = 1'b1;
            end
          end else if (is_space) begin
            // spaces are padding anywhere inside a field
          end else if (is_comma) begin
            if (!seen_q) begin
              do_err  = 1'b1;
              err_sel = E_EMPTY;
            end else if (idx_q == 2'd2) begin
              do_err  = 1'b1;
              err_sel = E_TOOMANY;
            end else begin
              do_store = 1'b1;
              idx_d    = idx_q + 2'd1;
              acc_d    = '0;
              seen_d   = 1'b0;
            end
          end else if (is_cr) begin
            if (!seen_q) begin
              do_err  = 1'b1;
              err_sel = E_EMPTY;
            end else begin
              do_store = 1'b1;
              state_d  = WAIT_LF;
            end
          end else if (is_dollar) begin
            do_start = 1'b1;
          end else begin
            do_err  = 1'b1;
            err_sel = E_BADCHAR;
          end
        end
        WAIT_LF: begin
          if (is_lf) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = id_q;
            cmd_arg1_d  = (idx_q >= 2'd1) ? a1_q : '0;
            cmd_arg2_d  = (idx_q == 2'd2) ? a2_q : '0;
            cmd_argc_d  = idx_q + 2'd1;
            state_d     = IDLE;
          end else if (is_dollar) begin
            do_start = 1'b1;
          end else begin
            do_err  = 1'b1;
            err_sel = E_NOLF;
          end
        end
        DISCARD: begin
          if (is_lf)          state_d  = IDLE;
          else if (is_dollar) do_start = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_store) begin
      case (idx_q)
        2'd0:    id_d = acc_q[ID_W-1:0];
        2'd1:    a1_d = acc_q[ARG_W-1:0];
        default: a2_d = acc_q[ARG_W-1:0];
      endcase
    end

    if (do_start) begin
      state_d = FIELD;
      idx_d   = 2'd0;
      acc_d   = '0;
      seen_d  = 1'b0;
    end

    if (do_err) begin
      cmd_err_d  = 1'b1;
      err_code_d = err_sel;
      state_d    = DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      seen_q      <= 1'b0;
      id_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_arg1_q  <= '0;
      cmd_arg2_q  <= '0;
      cmd_argc_q  <= '0;
      cmd_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      id_q        <= id_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_arg1_q  <= cmd_arg1_d;
      cmd_arg2_q  <= cmd_arg2_d;
      cmd_argc_q  <= cmd_argc_d;
      cmd_err_q   <= cmd_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_id    = cmd_id_q;
  assign bus.cmd_arg1  = cmd_arg1_q;
  assign bus.cmd_arg2  = cmd_arg2_q;
  assign bus.cmd_argc  = cmd_argc_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.err_code  = err_code_q;
endmodule
